// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of leaky integrate-and-fire neurons with shared threshold
// Optional aggregate spike counter enabled by defining LIF_SPIKE_COUNT_EN.
module lif_neuron_array #(
    parameter int N_NEURONS      = 4,
    parameter int WIDTH          = 8,
    parameter int LEAK_SHIFT     = 1,
    parameter int REFRACT_CYCLES = 2,
    parameter int RESET_MODE     = 0,
    localparam int SEL_W         = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_NEURONS*WIDTH-1:0]   current,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [SEL_W-1:0]             sel,
    output logic [N_NEURONS-1:0]         spike,
    output logic [WIDTH-1:0]             state_out,
    output logic [15:0]                  spike_count
);

    localparam logic [3:0]       REFR_LOAD = 4'(REFRACT_CYCLES);
    localparam logic [WIDTH-1:0] SAT_MAX   = {WIDTH{1'b1}};

    logic [WIDTH-1:0]     state_q   [N_NEURONS];
    logic [3:0]           refr_q    [N_NEURONS];
    logic [WIDTH-1:0]     state_d   [N_NEURONS];
    logic [3:0]           refr_d    [N_NEURONS];
    logic [N_NEURONS-1:0] spike_d;
    logic [4:0]           spike_pop;

    always_comb begin
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] sat;
        sum       = '0;
        sat       = '0;
        spike_d   = '0;
        spike_pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            state_d[i] = state_q[i];
            refr_d[i]  = refr_q[i];
            if (refr_q[i] != 4'd0) begin
                refr_d[i] = refr_q[i] - 4'd1;
            end else begin
                // Leak never underflows, so only the upper bound needs clamping.
                sum = {1'b0, state_q[i]} - {1'b0, state_q[i] >> LEAK_SHIFT}
                    + {1'b0, current[i*WIDTH +: WIDTH]};
                sat = sum[WIDTH] ? SAT_MAX : sum[WIDTH-1:0];
                if (sat >= threshold) begin
                    spike_d[i] = 1'b1;
                    refr_d[i]  = REFR_LOAD;
                    state_d[i] = (RESET_MODE == 1) ? sat - threshold : '0;
                end else begin
                    state_d[i] = sat;
                end
            end
            spike_pop = spike_pop + {4'd0, spike_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                refr_q[i]  <= '0;
            end
        end else if (en) begin
            spike <= spike_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= state_d[i];
                refr_q[i]  <= refr_d[i];
            end
        end else begin
            spike <= '0;
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (32'(sel) == i) state_out = state_q[i];
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] count_q;
    logic [16:0] count_sum;

    assign count_sum = {1'b0, count_q} + {12'd0, spike_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    assign spike_count = count_q;
`else
    logic unused_pop;
    assign unused_pop  = ^spike_pop;
    assign spike_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed checks for lif_neuron_array (zero-reset and subtract-reset instances)
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic [1:0]  sel;
    logic [3:0]  spike0, spike1;
    logic [7:0]  state0, state1;
    logic [15:0] count0, count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron_array dut0 (
        .clk(clk), .rst(rst), .en(en), .current(current), .threshold(threshold),
        .sel(sel), .spike(spike0), .state_out(state0), .spike_count(count0)
    );

    lif_neuron_array #(.RESET_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .current(current), .threshold(threshold),
        .sel(sel), .spike(spike1), .state_out(state1), .spike_count(count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Fire/refractory trace with current[0]=60, threshold=100.
    logic [7:0] fire_s0 [8] = '{8'd60, 8'd90, 8'd0, 8'd0, 8'd0, 8'd60, 8'd90, 8'd0};
    logic [7:0] fire_s1 [8] = '{8'd60, 8'd90, 8'd5, 8'd5, 8'd5, 8'd63, 8'd92, 8'd6};
    logic       fire_sp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] leak_s  [7] = '{8'd20, 8'd30, 8'd35, 8'd38, 8'd39, 8'd40, 8'd40};

    initial begin
        rst = 1'b1; en = 1'b1; current = '0; threshold = 8'd100; sel = 2'd0;
        step();
        check("reset_state", 32'(state0), 0);
        check("reset_spike", 32'(spike0), 0);
        check("reset_count", 32'(count0), 0);
        rst = 1'b0;

        current = 32'd20;
        for (int i = 0; i < 7; i++) begin
            step();
            check("leak_state", 32'(state0), 32'(leak_s[i]));
            check("leak_spike", 32'(spike0), 0);
        end

        do_reset();
        current = 32'd60;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fire_state0", 32'(state0), 32'(fire_s0[i]));
            check("fire_state1", 32'(state1), 32'(fire_s1[i]));
            check("fire_spike0", 32'(spike0), 32'(fire_sp[i]));
            check("fire_spike1", 32'(spike1), 32'(fire_sp[i]));
        end

        do_reset();
        sel = 2'd1; threshold = 8'd255; current = {8'd0, 8'd0, 8'd200, 8'd0};
        step();
        check("sat_first", 32'(state0), 200);
        step();
        check("sat_spike", 32'(spike0), 32'b0010);
        check("sat_state", 32'(state0), 0);
        check("sat_residual", 32'(state1), 0);
        do_reset();
        current = {8'd0, 8'd0, 8'd255, 8'd0};
        step();
        check("sat_max_spike", 32'(spike0), 32'b0010);
        check("sat_max_state", 32'(state0), 0);

        do_reset();
        sel = 2'd0; threshold = 8'd100; current = 32'd60;
        repeat (3) step();
        check("en_fire", 32'(spike0), 1);
        step();
        check("en_refr1", 32'(state0), 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_off_state0", 32'(state0), 0);
            check("en_off_state1", 32'(state1), 5);
            check("en_off_spike", 32'(spike0), 0);
        end
        en = 1'b1;
        step();
        check("en_refr2", 32'(state0), 0);
        check("en_refr2_s1", 32'(state1), 5);
        step();
        check("en_resume", 32'(state0), 60);
        check("en_resume_s1", 32'(state1), 63);

        step();
        check("rst_pre", 32'(state0), 90);
        rst = 1'b1;
        step();
        check("rst_mid_state", 32'(state0), 0);
        check("rst_mid_spike", 32'(spike0), 0);
        rst = 1'b0;

        current = '0; threshold = 8'd0;
        step();
        check("thr0_spike", 32'(spike0), 32'b1111);

        do_reset();
        current = 32'hFFFF_FFFF; threshold = 8'd1;
        step();
        check("all_spike", 32'(spike0), 32'b1111);
`ifdef LIF_SPIKE_COUNT_EN
        check("count_first", 32'(count0), 4);
        repeat (2) step();
        check("count_refr", 32'(count0), 4);
        step();
        check("count_second", 32'(count0), 8);
        repeat (50000) step();
        check("count_sat", 32'(count0), 32'hFFFF);
`else
        check("count_off", 32'(count0), 0);
        repeat (3) step();
        check("count_off2", 32'(count0), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
